pmp_check_arbiter: RTL and testbench
====================================

PMP_CHECK_ARBITER -- requirements
Module: pmp_check_arbiter

Interface
REQ-001 SHALL have parameter PLEN, default 34, physical address width.
REQ-002 SHALL have parameter NrReq, fixed at 2; requester 0 is instruction fetch and requester 1 is load/store.
REQ-003 SHALL have port clk_i, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port flush_i, input, 1, abort any in-flight check.
REQ-006 SHALL have port cfg_update_i, input, 1, PMP address/config CSR written this cycle.
REQ-007 SHALL have port req_valid_i, input, [NrReq-1:0], per-requester check request.
REQ-008 SHALL have port req_ready_o, output, [NrReq-1:0], per-requester request accepted.
REQ-009 SHALL have port req_addr_i, input, [NrReq-1:0][PLEN-1:0], address to check.
REQ-010 SHALL have port req_access_i, input, [NrReq-1:0] of riscv::pmp_access_t, access type.
REQ-011 SHALL have port req_priv_i, input, [NrReq-1:0] of riscv::priv_lvl_t, privilege level.
REQ-012 SHALL have port rsp_valid_o, output, [NrReq-1:0], per-requester result valid.
REQ-013 SHALL have port rsp_ready_i, input, [NrReq-1:0], per-requester result consumed.
REQ-014 SHALL have port rsp_allow_o, output, 1, result: 1 = access permitted.
REQ-015 SHALL have ports pmp_addr_o (output, PLEN), pmp_access_o (output, pmp_access_t) and pmp_priv_o (output, priv_lvl_t), driving the shared combinational PMP checker.
REQ-016 SHALL have port pmp_allow_i, input, 1, checker result for the driven operands.
REQ-017 SHALL have port deny_cnt_o, output, 16, count of denied responses delivered.

Function
REQ-018 SHALL implement FSM states IDLE, CHECK, RESP.
REQ-019 IDLE: if any req_valid_i and cfg_update_i=0 and flush_i=0, SHALL grant exactly one requester by assert of its req_ready_o that cycle, latch its addr/access/priv and id, then go to CHECK.
REQ-020 req_ready_o SHALL be 0 in CHECK and RESP, and in IDLE while cfg_update_i or flush_i is 1.
REQ-021 Arbitration SHALL be round-robin: with both valid, grant the requester not granted last; with one valid, grant it; last-grant updates only on grant.
REQ-022 pmp_*_o SHALL always present the latched operands; ungranted input changes SHALL NOT affect them.
REQ-023 CHECK: if cfg_update_i=0, SHALL register pmp_allow_i into rsp_allow_o and go to RESP; if cfg_update_i=1, SHALL stay in CHECK and re-evaluate next cycle against the new configuration.
REQ-024 RESP: rsp_valid_o[id] SHALL be 1 and all other bits 0; rsp_allow_o SHALL be held stable.
REQ-025 RESP SHALL stay until rsp_ready_i[id]=1, then go to IDLE; a new grant is possible no earlier than the following cycle.
REQ-026 Minimum latency: grant in cycle N leads to rsp_valid_o in cycle N+2; minimum spacing between grants is 3 cycles.
REQ-027 cfg_update_i in RESP SHALL NOT alter the result; it is ordered before the CSR write.
REQ-028 flush_i in any state SHALL force IDLE next cycle with no response; a RESP handshake completing in the flush cycle counts as delivered.
REQ-029 flush_i and valid requests in IDLE in the same cycle SHALL produce no grant.
REQ-030 deny_cnt_o SHALL increment by 1 on each completed RESP handshake with rsp_allow_o=0, and SHALL saturate at 16'hFFFF with no wrap.
REQ-031 rsp_valid_o SHALL never have more than one bit set.

Reset
REQ-032 On rst_ni=0, SHALL go to IDLE asynchronously and clear req_ready_o, rsp_valid_o, rsp_allow_o, deny_cnt_o and the latched operands to 0; last-grant SHALL reset to 1 so requester 0 wins first.
REQ-033 Reset asserted mid-CHECK or mid-RESP SHALL discard the transaction with no response after reset release.

Verification
REQ-034 Both valid after reset, pmp_allow_i=1 -> req_ready_o=01 at N, rsp_valid_o=01 with allow=1 at N+2; next grant to req1.
REQ-035 Req1 only, access W, pmp_allow_i=0, rsp_ready_i low 3 cycles -> rsp_valid_o=10 held 4 cycles, allow=0, deny_cnt_o 0 to 1.
REQ-036 cfg_update_i=1 for 2 cycles during CHECK, pmp_allow_i flips 1 to 0 -> response delayed 2 cycles, allow=0.
REQ-037 flush_i in CHECK -> no rsp_valid_o, IDLE next cycle; a pending req0 is granted the cycle after.
REQ-038 Force deny_cnt_o=16'hFFFE, deliver 3 denies -> value 16'hFFFF, held.
REQ-039 rst_ni low during RESP -> all outputs 0 immediately; after release, req0 wins a simultaneous request.

Source files
------------

// File: rtl/riscv.sv
// Shared RISC-V privilege and PMP access encodings used by the PMP check path.
package riscv;

   typedef enum logic [2:0] {
      ACCESS_NONE  = 3'b000,
      ACCESS_READ  = 3'b001,
      ACCESS_WRITE = 3'b010,
      ACCESS_EXEC  = 3'b100
   } pmp_access_t;

   typedef enum logic [1:0] {
      PRIV_LVL_U = 2'b00,
      PRIV_LVL_S = 2'b01,
      PRIV_LVL_M = 2'b11
   } priv_lvl_t;

endpackage

// File: rtl/pmp_check_arbiter.sv
// Shares one combinational PMP checker between instruction fetch (requester 0)
// and load/store (requester 1). Round-robin grant, registered result, and a
// saturating count of denied responses.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a request; grants one when no cfg write or flush
// CHECK | latched operands drive the checker; result sampled unless a
//       | PMP CSR write is in progress this cycle
// RESP  | rsp_valid_o[id] held with a stable result until consumed
module pmp_check_arbiter #(
   parameter int unsigned PLEN  = 34,
   parameter int unsigned NrReq = 2
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           flush_i,
   input  logic                           cfg_update_i,
   input  logic [NrReq-1:0]               req_valid_i,
   output logic [NrReq-1:0]               req_ready_o,
   input  logic [NrReq-1:0][PLEN-1:0]     req_addr_i,
   input  riscv::pmp_access_t [NrReq-1:0] req_access_i,
   input  riscv::priv_lvl_t   [NrReq-1:0] req_priv_i,
   output logic [NrReq-1:0]               rsp_valid_o,
   input  logic [NrReq-1:0]               rsp_ready_i,
   output logic                           rsp_allow_o,
   output logic [PLEN-1:0]                pmp_addr_o,
   output riscv::pmp_access_t             pmp_access_o,
   output riscv::priv_lvl_t               pmp_priv_o,
   input  logic                           pmp_allow_i,
   output logic [15:0]                    deny_cnt_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      RESP  = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic               run_q;
   logic               last_grant_q;
   logic               id_q;
   logic [PLEN-1:0]    addr_q;
   riscv::pmp_access_t access_q;
   riscv::priv_lvl_t   priv_q;
   logic               allow_q;
   logic [15:0]        deny_cnt_q;

   logic               grant;
   logic               gnt_id;
   logic               allow_load;
   logic               deliver;

   assign pmp_addr_o   = addr_q;
   assign pmp_access_o = access_q;
   assign pmp_priv_o   = priv_q;
   assign rsp_allow_o  = allow_q;
   assign deny_cnt_o   = deny_cnt_q;

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Grant enable: low while in reset and for the first edge after release,
   // so req_ready_o is never asserted while rst_ni is low.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         run_q <= 1'b0;
      end else begin
         run_q <= 1'b1;
      end
   end

   // Next-state, arbitration and handshake outputs.
   always_comb begin
      state_d     = state_q;
      grant       = 1'b0;
      gnt_id      = 1'b0;
      allow_load  = 1'b0;
      deliver     = 1'b0;
      req_ready_o = '0;
      rsp_valid_o = '0;
      case (state_q)
         IDLE: begin
            if (run_q && (|req_valid_i) && !cfg_update_i && !flush_i) begin
               grant = 1'b1;
               // Both valid: the one not granted last; otherwise the lone one.
               if (&req_valid_i) begin
                  gnt_id = ~last_grant_q;
               end else begin
                  gnt_id = req_valid_i[1];
               end
               req_ready_o[gnt_id] = 1'b1;
               state_d = CHECK;
            end
         end
         CHECK: begin
            if (flush_i) begin
               state_d = IDLE;
            end else if (!cfg_update_i) begin
               allow_load = 1'b1;
               state_d    = RESP;
            end
         end
         RESP: begin
            rsp_valid_o[id_q] = 1'b1;
            // A handshake in the flush cycle still counts as delivered.
            if (rsp_ready_i[id_q]) begin
               deliver = 1'b1;
               state_d = IDLE;
            end
            if (flush_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Operand latch on grant; ungranted input changes never reach the checker.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         last_grant_q <= 1'b1;
         id_q         <= 1'b0;
         addr_q       <= '0;
         access_q     <= riscv::ACCESS_NONE;
         priv_q       <= riscv::PRIV_LVL_U;
      end else if (grant) begin
         last_grant_q <= gnt_id;
         id_q         <= gnt_id;
         addr_q       <= req_addr_i[gnt_id];
         access_q     <= req_access_i[gnt_id];
         priv_q       <= req_priv_i[gnt_id];
      end
   end

   // Result register, loaded only when leaving CHECK so it is stable in RESP.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         allow_q <= 1'b0;
      end else if (allow_load) begin
         allow_q <= pmp_allow_i;
      end
   end

   // Saturating count of delivered denies.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         deny_cnt_q <= '0;
      end else if (deliver && !allow_q && (deny_cnt_q != 16'hFFFF)) begin
         deny_cnt_q <= deny_cnt_q + 16'd1;
      end
   end

endmodule

// File: tb/tb_pmp_check_arbiter.sv
// Directed bench for pmp_check_arbiter with a response scoreboard.
module tb_pmp_check_arbiter;

   logic                     clk_i = 1'b0;
   logic                     rst_ni;
   logic                     flush_i;
   logic                     cfg_update_i;
   logic [1:0]               req_valid_i;
   logic [1:0]               req_ready_o;
   logic [1:0][33:0]         req_addr_i;
   riscv::pmp_access_t [1:0] req_access_i;
   riscv::priv_lvl_t   [1:0] req_priv_i;
   logic [1:0]               rsp_valid_o;
   logic [1:0]               rsp_ready_i;
   logic                     rsp_allow_o;
   logic [33:0]              pmp_addr_o;
   riscv::pmp_access_t       pmp_access_o;
   riscv::priv_lvl_t         pmp_priv_o;
   logic                     pmp_allow_i;
   logic [15:0]              deny_cnt_o;

   typedef struct packed {
      logic id;
      logic allow;
   } exp_t;

   exp_t        sb_q[$];
   int          n_assert = 0;
   int          n_fail   = 0;
   logic [15:0] exp_deny = 16'd0;

   pmp_check_arbiter #(.PLEN(34), .NrReq(2)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .flush_i      (flush_i),
      .cfg_update_i (cfg_update_i),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .req_addr_i   (req_addr_i),
      .req_access_i (req_access_i),
      .req_priv_i   (req_priv_i),
      .rsp_valid_o  (rsp_valid_o),
      .rsp_ready_i  (rsp_ready_i),
      .rsp_allow_o  (rsp_allow_o),
      .pmp_addr_o   (pmp_addr_o),
      .pmp_access_o (pmp_access_o),
      .pmp_priv_o   (pmp_priv_o),
      .pmp_allow_i  (pmp_allow_i),
      .deny_cnt_o   (deny_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Pop the next expected response and compare; the caller completes the
   // handshake this cycle, so the deny model advances here.
   task automatic sb_check();
      exp_t e;
      chk("sb_pending", 64'(sb_q.size() > 0), 64'd1);
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk("rsp_valid", 64'(rsp_valid_o), 64'(2'b01 << e.id));
         chk("rsp_allow", 64'(rsp_allow_o), 64'(e.allow));
         if (!e.allow && exp_deny != 16'hFFFF) exp_deny = exp_deny + 16'd1;
      end
   endtask

   task automatic wait_rsp(input int budget, output bit got);
      got = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk_i); #1;
         if (rsp_valid_o != 2'b00) begin
            got = 1'b1;
            break;
         end
      end
      chk("rsp_timeout", 64'(got), 64'd1);
   endtask

   task automatic txn(input int id, input logic allow);
      bit   got;
      logic [1:0] oh;
      oh = 2'b01 << id;
      @(negedge clk_i);
      req_valid_i = oh;
      pmp_allow_i = allow;
      #1;
      chk("txn_grant", 64'(req_ready_o), 64'(oh));
      sb_q.push_back('{id: id[0], allow: allow});
      @(negedge clk_i);
      req_valid_i = 2'b00;
      #1;
      chk("txn_ready_low", 64'(req_ready_o), 64'd0);
      wait_rsp(6, got);
      if (got) begin
         rsp_ready_i = oh;
         sb_check();
      end else if (sb_q.size() > 0) begin
         void'(sb_q.pop_front());
      end
      @(negedge clk_i);
      rsp_ready_i = 2'b00;
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      bit got;
      rst_ni          = 1'b0;
      flush_i         = 1'b0;
      cfg_update_i    = 1'b0;
      req_valid_i     = 2'b11;
      rsp_ready_i     = 2'b00;
      req_addr_i[0]   = 34'h1_2345_6780;
      req_addr_i[1]   = 34'h2_0000_0040;
      req_access_i[0] = riscv::ACCESS_EXEC;
      req_access_i[1] = riscv::ACCESS_READ;
      req_priv_i[0]   = riscv::PRIV_LVL_M;
      req_priv_i[1]   = riscv::PRIV_LVL_S;
      pmp_allow_i     = 1'b0;

      // Reset values, with both requests already pending.
      repeat (2) @(negedge clk_i);
      #1;
      chk("rst_ready", 64'(req_ready_o), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
      chk("rst_allow", 64'(rsp_allow_o), 64'd0);
      chk("rst_deny", 64'(deny_cnt_o), 64'd0);
      chk("rst_addr", 64'(pmp_addr_o), 64'd0);
      chk("rst_access", 64'(pmp_access_o), 64'd0);
      chk("rst_priv", 64'(pmp_priv_o), 64'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      req_valid_i = 2'b00;

      // Both valid after reset: requester 0 first, response at N+2.
      @(negedge clk_i);
      req_valid_i = 2'b11;
      pmp_allow_i = 1'b1;
      #1;
      chk("a_grant", 64'(req_ready_o), 64'b01);
      sb_q.push_back('{id: 1'b0, allow: 1'b1});
      @(negedge clk_i);
      req_valid_i     = 2'b10;
      req_addr_i[0]   = 34'h0_DEAD_BEE0;
      req_access_i[0] = riscv::ACCESS_READ;
      #1;
      chk("a_ready_check", 64'(req_ready_o), 64'd0);
      chk("a_no_rsp_n1", 64'(rsp_valid_o), 64'd0);
      chk("a_addr", 64'(pmp_addr_o), 64'h1_2345_6780);
      chk("a_access", 64'(pmp_access_o), 64'(riscv::ACCESS_EXEC));
      chk("a_priv", 64'(pmp_priv_o), 64'(riscv::PRIV_LVL_M));
      @(negedge clk_i);
      rsp_ready_i = 2'b01;
      #1;
      sb_check();

      // Round robin to requester 1; write access denied; slow consumer.
      @(negedge clk_i);
      rsp_ready_i     = 2'b00;
      req_valid_i     = 2'b11;
      req_addr_i[1]   = 34'h3_0000_0100;
      req_access_i[1] = riscv::ACCESS_WRITE;
      req_priv_i[1]   = riscv::PRIV_LVL_U;
      pmp_allow_i     = 1'b0;
      #1;
      chk("b_grant_rr", 64'(req_ready_o), 64'b10);
      chk("b_deny0", 64'(deny_cnt_o), 64'd0);
      sb_q.push_back('{id: 1'b1, allow: 1'b0});
      @(negedge clk_i);
      req_valid_i = 2'b01;
      rsp_ready_i = 2'b01;
      #1;
      chk("b_ready_check", 64'(req_ready_o), 64'd0);
      chk("b_addr", 64'(pmp_addr_o), 64'h3_0000_0100);
      chk("b_access", 64'(pmp_access_o), 64'(riscv::ACCESS_WRITE));
      chk("b_priv", 64'(pmp_priv_o), 64'(riscv::PRIV_LVL_U));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         rsp_ready_i = 2'b01;
         #1;
         chk("b_rsp_hold", 64'(rsp_valid_o), 64'b10);
         chk("b_allow_hold", 64'(rsp_allow_o), 64'd0);
         chk("b_deny_hold", 64'(deny_cnt_o), 64'd0);
      end
      @(negedge clk_i);
      rsp_ready_i = 2'b10;
      #1;
      sb_check();

      // Config write during CHECK delays the result by two cycles.
      @(negedge clk_i);
      rsp_ready_i = 2'b00;
      pmp_allow_i = 1'b1;
      #1;
      chk("c_deny1", 64'(deny_cnt_o), 64'(exp_deny));
      chk("c_grant", 64'(req_ready_o), 64'b01);
      sb_q.push_back('{id: 1'b0, allow: 1'b0});
      @(negedge clk_i);
      req_valid_i  = 2'b00;
      cfg_update_i = 1'b1;
      #1;
      chk("c_stall1", 64'(rsp_valid_o), 64'd0);
      @(negedge clk_i);
      pmp_allow_i = 1'b0;
      #1;
      chk("c_stall2", 64'(rsp_valid_o), 64'd0);
      @(negedge clk_i);
      cfg_update_i = 1'b0;
      #1;
      chk("c_stall3", 64'(rsp_valid_o), 64'd0);
      @(negedge clk_i);
      rsp_ready_i = 2'b01;
      #1;
      sb_check();

      // Flush during CHECK: no response, pending req0 granted right after.
      @(negedge clk_i);
      rsp_ready_i = 2'b00;
      req_valid_i = 2'b11;
      pmp_allow_i = 1'b1;
      #1;
      chk("d_deny2", 64'(deny_cnt_o), 64'(exp_deny));
      chk("d_grant", 64'(req_ready_o), 64'b10);
      @(negedge clk_i);
      flush_i = 1'b1;
      #1;
      chk("d_ready_flush", 64'(req_ready_o), 64'd0);
      @(negedge clk_i);
      flush_i = 1'b0;
      #1;
      chk("d_no_rsp", 64'(rsp_valid_o), 64'd0);
      chk("d_regrant", 64'(req_ready_o), 64'b01);
      sb_q.push_back('{id: 1'b0, allow: 1'b1});
      @(negedge clk_i);
      req_valid_i = 2'b00;
      #1;
      chk("d_addr", 64'(pmp_addr_o), 64'h0_DEAD_BEE0);

      // Config write during RESP leaves the result untouched.
      @(negedge clk_i);
      cfg_update_i = 1'b1;
      pmp_allow_i  = 1'b0;
      #1;
      chk("e_rsp_valid", 64'(rsp_valid_o), 64'b01);
      chk("e_allow_held", 64'(rsp_allow_o), 64'd1);
      @(negedge clk_i);
      cfg_update_i = 1'b0;
      rsp_ready_i  = 2'b01;
      #1;
      sb_check();

      // No grant while cfg_update_i or flush_i in IDLE.
      @(negedge clk_i);
      rsp_ready_i  = 2'b00;
      req_valid_i  = 2'b11;
      cfg_update_i = 1'b1;
      #1;
      chk("f_cfg_block", 64'(req_ready_o), 64'd0);
      @(negedge clk_i);
      cfg_update_i = 1'b0;
      flush_i      = 1'b1;
      #1;
      chk("f_flush_block", 64'(req_ready_o), 64'd0);
      @(negedge clk_i);
      flush_i     = 1'b0;
      pmp_allow_i = 1'b0;
      #1;
      chk("f_grant", 64'(req_ready_o), 64'b10);
      sb_q.push_back('{id: 1'b1, allow: 1'b0});
      @(negedge clk_i);
      req_valid_i = 2'b00;
      // Handshake in the same cycle as a flush still counts.
      @(negedge clk_i);
      flush_i     = 1'b1;
      rsp_ready_i = 2'b10;
      #1;
      sb_check();
      @(negedge clk_i);
      flush_i     = 1'b0;
      rsp_ready_i = 2'b00;
      #1;
      chk("f_deny3", 64'(deny_cnt_o), 64'(exp_deny));
      chk("f_idle", 64'(rsp_valid_o), 64'd0);

      // Saturation from a preloaded counter value.
      force dut.deny_cnt_q = 16'hFFFE;
      #1;
      release dut.deny_cnt_q;
      exp_deny = 16'hFFFE;
      #1;
      chk("g_preload", 64'(deny_cnt_o), 64'(exp_deny));
      for (int i = 0; i < 3; i++) begin
         txn(i % 2, 1'b0);
         chk("g_deny_sat", 64'(deny_cnt_o), 64'(exp_deny));
      end

      // Reset in RESP discards the transaction; req0 wins afterwards.
      @(negedge clk_i);
      req_valid_i = 2'b01;
      pmp_allow_i = 1'b1;
      #1;
      chk("h_grant", 64'(req_ready_o), 64'b01);
      @(negedge clk_i);
      req_valid_i = 2'b00;
      @(negedge clk_i);
      #1;
      chk("h_in_resp", 64'(rsp_valid_o), 64'b01);
      rst_ni      = 1'b0;
      req_valid_i = 2'b11;
      #1;
      chk("h_rst_ready", 64'(req_ready_o), 64'd0);
      chk("h_rst_rsp", 64'(rsp_valid_o), 64'd0);
      chk("h_rst_allow", 64'(rsp_allow_o), 64'd0);
      chk("h_rst_deny", 64'(deny_cnt_o), 64'd0);
      chk("h_rst_addr", 64'(pmp_addr_o), 64'd0);
      chk("h_rst_access", 64'(pmp_access_o), 64'd0);
      chk("h_rst_priv", 64'(pmp_priv_o), 64'd0);
      sb_q.delete();
      exp_deny = 16'd0;
      @(negedge clk_i);
      rst_ni = 1'b1;
      #1;
      chk("h_no_rsp_rel", 64'(rsp_valid_o), 64'd0);
      @(negedge clk_i);
      #1;
      chk("h_req0_wins", 64'(req_ready_o), 64'b01);
      chk("h_no_rsp", 64'(rsp_valid_o), 64'd0);
      sb_q.push_back('{id: 1'b0, allow: 1'b1});
      @(negedge clk_i);
      req_valid_i = 2'b00;
      wait_rsp(6, got);
      if (got) begin
         rsp_ready_i = 2'b01;
         sb_check();
      end
      @(negedge clk_i);
      rsp_ready_i = 2'b00;
      #1;
      chk("h_deny_after", 64'(deny_cnt_o), 64'(exp_deny));
      chk("sb_drained", 64'(sb_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
